// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg: shared size codes, sequencer states and alignment check
package mem_xfer_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ACCESS, S_DONE, S_FAIL} state_t;
  function automatic logic misaligned(size_t s, logic [1:0] off);
    return s == SZ_RSVD || (s == SZ_HALF && off[0]) || (s == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: byte-lane enables, write replication and read extension
module mem_lane_unit
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_t               size,
  input  logic [1:0]          off,
  input  logic [DATA_W-1:0]   mdr,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                sext,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rext
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] sh, mask;
  logic neg;
  // lane enables, and read data shifted down then masked and sign/zero filled
  always_comb begin
    be = size == SZ_BYTE ? NB'(1) << off : size == SZ_HALF ? NB'(3) << off : size == SZ_WORD ? NB'(15) : '0;
    sh = rdata >> {off, 3'b000};
    mask = size == SZ_BYTE ? DATA_W'(8'hFF) : size == SZ_HALF ? DATA_W'(16'hFFFF) : DATA_W'(32'hFFFF_FFFF);
    neg = sext & (size == SZ_BYTE ? sh[7] : size == SZ_HALF ? sh[15] : sh[31]);
    rext = (sh & mask) | (neg ? ~mask : '0);
  end
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign wdata[8*k+:8] = size == SZ_BYTE ? mdr[7:0] : size == SZ_HALF ? mdr[8*(k%2)+:8] : mdr[8*k+:8];
  end
endmodule

// File: rtl/mem_xfer_regs.sv
// mem_xfer_regs: MAR/MDR pair with a single-transfer memory sequencer
module mem_xfer_regs
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mar_ld,
  input  logic [ADDR_W-1:0]   mar_d,
  input  logic                mdr_ld,
  input  logic [DATA_W-1:0]   mdr_d,
  input  logic                mfa,
  input  logic                rw,
  input  logic [1:0]          size,
  input  logic                sext,
  output logic [ADDR_W-1:0]   mar_q,
  output logic [DATA_W-1:0]   mdr_q,
  output logic                busy,
  output logic                moc,
  output logic                err,
  output logic                err_to,
  output logic                mem_en,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_moc
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  size_t size_q;
  logic rw_q, sext_q, timeout, idle;
  logic [CW-1:0] cnt;
  logic [NB-1:0] be;
  logic [DATA_W-1:0] rext;
  mem_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .size(size_q), .off(mar_q[1:0]), .mdr(mdr_q), .rdata(mem_rdata), .sext(sext_q),
    .be(be), .wdata(mem_wdata), .rext(rext)
  );
  assign idle     = state == S_IDLE;
  assign timeout  = cnt == CW'(TIMEOUT - 1);
  assign mem_rw   = rw_q;
  assign mem_addr = mar_q & ~ADDR_W'(NB - 1);
  assign mem_be   = mem_en ? be : '0;
  // next state and state-decoded strobes
  always_comb begin
    nxt = state;
    busy = !idle;
    mem_en = state == S_ACCESS;
    moc = state == S_DONE;
    err = state == S_FAIL;
    case (state)
      S_IDLE:   nxt = mfa ? S_CHECK : S_IDLE;
      S_CHECK:  nxt = misaligned(size_q, mar_q[1:0]) ? S_FAIL : S_ACCESS;
      S_ACCESS: nxt = mem_moc ? S_DONE : timeout ? S_FAIL : S_ACCESS;
      default:  nxt = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // address/data registers, latched request, abort cause and access timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q <= '0;
      mdr_q <= '0;
      size_q <= SZ_BYTE;
      rw_q <= 1'b0;
      sext_q <= 1'b0;
      err_to <= 1'b0;
      cnt <= '0;
    end else begin
      if (idle && mar_ld) mar_q <= mar_d;
      if (idle && mdr_ld) mdr_q <= mdr_d;
      else if (mem_en && mem_moc && rw_q) mdr_q <= rext;
      if (idle && mfa) begin
        size_q <= size_t'(size);
        rw_q <= rw;
        sext_q <= sext;
        err_to <= 1'b0;
      end else if (mem_en && !mem_moc && timeout) err_to <= 1'b1;
      cnt <= mem_en ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_mem_xfer_regs.sv
// tb_mem_xfer_regs: table-driven transfers plus timeout, reset and busy-load sequences
module tb_mem_xfer_regs;
  logic clk = 0, rst_n = 0;
  logic mar_ld = 0, mdr_ld = 0, mfa = 0, rw = 0, sext = 0, mem_moc = 0;
  logic [7:0] mar_d = 0;
  logic [31:0] mdr_d = 0, mem_rdata = 0;
  logic [1:0] size = 0;
  logic [7:0] mar_q, mem_addr;
  logic [31:0] mdr_q, mem_wdata;
  logic [3:0] mem_be;
  logic busy, moc, err, err_to, mem_en, mem_rw;
  int checks = 0, errors = 0, cnt_en;

  mem_xfer_regs #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .mar_ld(mar_ld), .mar_d(mar_d), .mdr_ld(mdr_ld), .mdr_d(mdr_d),
    .mfa(mfa), .rw(rw), .size(size), .sext(sext), .mar_q(mar_q), .mdr_q(mdr_q), .busy(busy),
    .moc(moc), .err(err), .err_to(err_to), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mar; logic [31:0] mdr; logic rw; logic [1:0] size; logic sx; logic [31:0] rdata;
    logic [3:0] be; logic [7:0] addr; logic [31:0] wdata; logic [31:0] mdr_exp; logic err;
  } vec_t;
  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] a, input logic [31:0] d, input logic r, input logic [1:0] s, input logic x);
    mar_d = a; mdr_d = d; mar_ld = 1; mdr_ld = 1; mfa = 1; rw = r; size = s; sext = x;
    tick();
    mar_ld = 0; mdr_ld = 0; mfa = 0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string n;
    n = $sformatf("v%0d", i);
    start(v.mar, v.mdr, v.rw, v.size, v.sx);
    chk({n, " c1 busy"}, busy, 1);
    chk({n, " c1 en"}, mem_en, 0);
    tick();
    if (v.err) begin
      chk({n, " err"}, err, 1);
      chk({n, " en"}, mem_en, 0);
      chk({n, " err_to"}, err_to, 0);
      tick();
      chk({n, " err pulse"}, err, 0);
      chk({n, " idle"}, busy, 0);
      chk({n, " mdr kept"}, mdr_q, v.mdr);
    end else begin
      chk({n, " en"}, mem_en, 1);
      chk({n, " rw"}, mem_rw, v.rw);
      chk({n, " be"}, mem_be, v.be);
      chk({n, " addr"}, mem_addr, v.addr);
      if (!v.rw) chk({n, " wdata"}, mem_wdata, v.wdata);
      tick();
      tick();
      chk({n, " c4 moc"}, moc, 0);
      mem_moc = 1; mem_rdata = v.rdata;
      tick();
      mem_moc = 0; mem_rdata = 0;
      chk({n, " moc"}, moc, 1);
      chk({n, " err0"}, err, 0);
      chk({n, " en off"}, mem_en, 0);
      chk({n, " mdr"}, mdr_q, v.mdr_exp);
      tick();
      chk({n, " moc pulse"}, moc, 0);
      chk({n, " idle"}, busy, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h10, 32'h0, 1, 2'b10, 0, 32'hDEADBEEF, 4'b1111, 8'h10, 32'h0, 32'hDEADBEEF, 0};
    vecs[1]  = '{8'h13, 32'h0, 1, 2'b00, 1, 32'h80112233, 4'b1000, 8'h10, 32'h0, 32'hFFFFFF80, 0};
    vecs[2]  = '{8'h13, 32'h0, 1, 2'b00, 0, 32'h80112233, 4'b1000, 8'h10, 32'h0, 32'h00000080, 0};
    vecs[3]  = '{8'h22, 32'h0000ABCD, 0, 2'b01, 0, 32'h0, 4'b1100, 8'h20, 32'hABCDABCD, 32'h0000ABCD, 0};
    vecs[4]  = '{8'h05, 32'h11, 1, 2'b10, 0, 32'h0, 4'b0, 8'h04, 32'h0, 32'h0, 1};
    vecs[5]  = '{8'h12, 32'h0, 1, 2'b01, 1, 32'h80010000, 4'b1100, 8'h10, 32'h0, 32'hFFFF8001, 0};
    vecs[6]  = '{8'h41, 32'h000000A5, 0, 2'b00, 0, 32'h0, 4'b0010, 8'h40, 32'hA5A5A5A5, 32'h000000A5, 0};
    vecs[7]  = '{8'h00, 32'h22, 1, 2'b11, 0, 32'h0, 4'b0, 8'h00, 32'h0, 32'h0, 1};
    vecs[8]  = '{8'h03, 32'h33, 0, 2'b01, 0, 32'h0, 4'b0, 8'h00, 32'h0, 32'h0, 1};
    vecs[9]  = '{8'h00, 32'h0, 1, 2'b00, 0, 32'h123456F0, 4'b0001, 8'h00, 32'h0, 32'h000000F0, 0};
    vecs[10] = '{8'h0E, 32'h0, 1, 2'b01, 0, 32'h7FFF0000, 4'b1100, 8'h0C, 32'h0, 32'h00007FFF, 0};
    for (int i = 0; i < 11; i++)
      if (vecs[i].err) vecs[i].mdr_exp = vecs[i].mdr;
    #12 rst_n = 1;
    #1;
    chk("rst mar", mar_q, 0);
    chk("rst mdr", mdr_q, 0);
    chk("rst outs", {busy, moc, err, err_to, mem_en, mem_rw, mem_be}, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    tick();
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    start(8'h08, 32'h5A5A5A5A, 1, 2'b10, 0);
    tick();
    cnt_en = 0;
    for (int i = 0; i < 40 && mem_en; i++) begin
      cnt_en++;
      tick();
    end
    chk("to en cycles", cnt_en, 15);
    chk("to err", err, 1);
    chk("to err_to", err_to, 1);
    chk("to moc", moc, 0);
    tick();
    chk("to err pulse", err, 0);
    chk("to err_to held", err_to, 1);
    chk("to mdr kept", mdr_q, 32'h5A5A5A5A);

    start(8'h08, 32'h0, 1, 2'b10, 0);
    chk("edge err_to clr", err_to, 0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("edge en15", mem_en, 1);
    mem_moc = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_moc = 0; mem_rdata = 0;
    chk("edge moc", moc, 1);
    chk("edge err", err, 0);
    chk("edge mdr", mdr_q, 32'hCAFEF00D);
    tick();

    start(8'h30, 32'h77, 1, 2'b10, 0);
    mar_ld = 1; mar_d = 8'h99;
    tick();
    mar_ld = 0;
    chk("busy ld mar", mar_q, 8'h30);
    chk("busy ld addr", mem_addr, 8'h30);
    chk("busy en", mem_en, 1);
    #2 rst_n = 0;
    #1;
    chk("arst en", mem_en, 0);
    chk("arst busy", busy, 0);
    chk("arst mar", mar_q, 0);
    chk("arst mdr", mdr_q, 0);
    #2 rst_n = 1;
    tick();
    chk("post rst moc/err", {moc, err}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
